// File: rtl/xbar_cfg_loader_if.sv
// rtl/xbar_cfg_loader_if.sv - byte-wide config word stream between a source and the crossbar config loader
interface xbar_cfg_loader_if #(
  parameter int WORD_W = 8
) ();
  logic [WORD_W-1:0] io_cfg_in;
  logic              io_cfg_in_valid;
  logic              io_cfg_in_ready;

  modport master (
    output io_cfg_in,
    output io_cfg_in_valid,
    input  io_cfg_in_ready
  );

  modport slave (
    input  io_cfg_in,
    input  io_cfg_in_valid,
    output io_cfg_in_ready
  );
endinterface

// File: rtl/xbar_cfg_loader.sv
// rtl/xbar_cfg_loader.sv - assembles a shadow crossbar select image and commits it atomically
// Optional select range check enabled by defining XBAR_CFG_RANGE_CHECK_EN.
module xbar_cfg_loader #(
  parameter int WORD_W   = 8,
  parameter int SEL_W    = 5,
  parameter int N_OUT    = 30,
  parameter int N_IN     = 23,
  parameter int CFG_BITS = SEL_W * N_OUT,
  parameter int N_WORDS  = (CFG_BITS + WORD_W - 1) / WORD_W
) (
  input  logic                clk,
  input  logic                reset,
  xbar_cfg_loader_if.slave    cfg_s,
  input  logic                io_abort,
  output logic [CFG_BITS-1:0] io_mux_configs,
  output logic                io_cfg_loaded,
  output logic                io_done,
  output logic                io_cfg_err
);

  localparam int CNT_W = $clog2(N_WORDS);
  localparam int CMP_W = SEL_W + 1;

  typedef enum logic [1:0] {ST_LOAD, ST_CHECK, ST_COMMIT} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CFG_BITS-1:0] shadow_q, shadow_d;
  logic [CFG_BITS-1:0] active_q;
  logic                loaded_q;
  logic                accept, commit_en, last_word, range_bad;

  if (N_IN > (1 << SEL_W)) begin : g_bad_n_in
    $error("N_IN exceeds the range of a SEL_W-bit select");
  end

  assign last_word = (cnt_q == CNT_W'(N_WORDS - 1));

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_LOAD;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (io_abort) begin
      state_d = ST_LOAD;
    end else begin
      case (state_q)
        ST_LOAD:   if (accept && last_word) state_d = ST_CHECK;
        ST_CHECK:  state_d = range_bad ? ST_LOAD : ST_COMMIT;
        ST_COMMIT: state_d = ST_LOAD;
        default:   state_d = ST_LOAD;
      endcase
    end
  end

  // Ready and done decode the state register only, so no input reaches an output combinationally.
  always_comb begin
    cfg_s.io_cfg_in_ready = (state_q == ST_LOAD);
    io_done               = (state_q == ST_COMMIT);
    accept                = (state_q == ST_LOAD) && cfg_s.io_cfg_in_valid && !io_abort;
    commit_en             = (state_q == ST_COMMIT) && !io_abort;
  end

  always_comb begin
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    if (io_abort) begin
      cnt_d    = '0;
      shadow_d = '0;
    end else if (accept) begin
      cnt_d = last_word ? '0 : cnt_q + 1'b1;
      // Bits of the final word beyond the image width are dropped.
      for (int k = 0; k < N_WORDS; k++) begin
        if (cnt_q == CNT_W'(k)) begin
          for (int b = 0; b < WORD_W; b++) begin
            if (k * WORD_W + b < CFG_BITS) shadow_d[k*WORD_W+b] = cfg_s.io_cfg_in[b];
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= '0;
      shadow_q <= '0;
      active_q <= '0;
      loaded_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      if (commit_en) begin
        active_q <= shadow_q;
        loaded_q <= 1'b1;
      end
    end
  end

`ifdef XBAR_CFG_RANGE_CHECK_EN
  logic err_q;

  always_comb begin
    range_bad = 1'b0;
    for (int i = 0; i < N_OUT; i++) begin
      if ({1'b0, shadow_q[i*SEL_W +: SEL_W]} >= CMP_W'(N_IN)) range_bad = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || io_abort)                       err_q <= 1'b0;
    else if (state_q == ST_CHECK && range_bad)   err_q <= 1'b1;
    else if (state_q == ST_COMMIT)               err_q <= 1'b0;
  end

  assign io_cfg_err = err_q;
`else
  assign range_bad  = 1'b0;
  assign io_cfg_err = 1'b0;
`endif

  assign io_mux_configs = active_q;
  assign io_cfg_loaded  = loaded_q;

endmodule

// File: tb/tb_xbar_cfg_loader.sv
// tb/tb_xbar_cfg_loader.sv - randomized bench for xbar_cfg_loader checked against an image-level model
module tb_xbar_cfg_loader;
  localparam int WORD_W   = 8;
  localparam int SEL_W    = 5;
  localparam int N_OUT    = 30;
  localparam int N_IN     = 23;
  localparam int CFG_BITS = 150;
  localparam int N_WORDS  = 19;
  localparam int PAD_W    = N_WORDS * WORD_W;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                io_abort = 1'b0;
  logic [CFG_BITS-1:0] io_mux_configs;
  logic                io_cfg_loaded, io_done, io_cfg_err;

  xbar_cfg_loader_if #(.WORD_W(WORD_W)) cfg_if ();

  xbar_cfg_loader dut (
    .clk           (clk),
    .reset         (reset),
    .cfg_s         (cfg_if),
    .io_abort      (io_abort),
    .io_mux_configs(io_mux_configs),
    .io_cfg_loaded (io_cfg_loaded),
    .io_done       (io_done),
    .io_cfg_err    (io_cfg_err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [CFG_BITS-1:0] act, input logic [CFG_BITS-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Model: collects accepted bytes; the image's fate is scheduled relative to its last accept.
  logic                exp_ready, exp_done, exp_err, exp_loaded;
  logic [CFG_BITS-1:0] exp_active, m_img;
  logic [PAD_W-1:0]    big;
  logic [7:0]          mb[$];
  bit                  m_good;
  bit                  model_on = 0;
  int                  cyc = 0;
  int                  t_last = -1;

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      mb.delete();
      t_last = -1;
      exp_ready = 1; exp_done = 0; exp_err = 0; exp_loaded = 0; exp_active = '0;
      model_on = 1;
    end else if (io_abort) begin
      mb.delete();
      t_last = -1;
      exp_ready = 1; exp_done = 0; exp_err = 0;
    end else if (t_last >= 0 && cyc == t_last + 2) begin
      exp_done = 0; exp_ready = 1; exp_active = m_img; exp_loaded = 1; exp_err = 0;
      t_last = -1;
    end else if (t_last >= 0 && cyc == t_last + 1) begin
      if (m_good) exp_done = 1;
      else begin
        exp_err = 1; exp_ready = 1; t_last = -1;
      end
    end else if (exp_ready && cfg_if.io_cfg_in_valid) begin
      mb.push_back(cfg_if.io_cfg_in);
      if (mb.size() == N_WORDS) begin
        big = '0;
        for (int k = N_WORDS - 1; k >= 0; k--) big = {big[PAD_W-WORD_W-1:0], mb[k]};
        m_img  = big[CFG_BITS-1:0];
        m_good = 1;
`ifdef XBAR_CFG_RANGE_CHECK_EN
        for (int i = 0; i < N_OUT; i++) if (int'(m_img[i*SEL_W +: SEL_W]) >= N_IN) m_good = 0;
`endif
        mb.delete();
        t_last = cyc;
        exp_ready = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      check("ready",  cfg_if.io_cfg_in_ready, exp_ready);
      check("done",   io_done, exp_done);
      check("err",    io_cfg_err, exp_err);
      check("loaded", io_cfg_loaded, exp_loaded);
      check("active", io_mux_configs, exp_active);
    end
  end

  logic [7:0] tx[N_WORDS];

  task automatic load_image(input logic [CFG_BITS-1:0] img, input logic [1:0] top);
    logic [PAD_W-1:0] p;
    p = {top, img};
    for (int k = 0; k < N_WORDS; k++) tx[k] = p[k*WORD_W +: WORD_W];
  endtask

  function automatic logic [CFG_BITS-1:0] rand_image(input bit bad);
    logic [CFG_BITS-1:0] img;
    int f;
    for (int i = 0; i < N_OUT; i++) img[i*SEL_W +: SEL_W] = SEL_W'($urandom_range(N_IN - 1, 0));
    if (bad) begin
      f = $urandom_range(N_OUT - 1, 0);
      img[f*SEL_W +: SEL_W] = SEL_W'($urandom_range(31, N_IN));
    end
    return img;
  endfunction

  task automatic align();
    @(posedge clk); #1;
  endtask

  task automatic send_words(input int first, input int last, input bit gaps);
    for (int k = first; k <= last; k++) begin
      bit acc;
      int guard;
      int idle;
      if (gaps) begin
        idle = $urandom_range(0, 3);
        cfg_if.io_cfg_in_valid = 0;
        repeat (idle) begin
          cfg_if.io_cfg_in = 8'($urandom);
          align();
        end
      end
      cfg_if.io_cfg_in = tx[k];
      cfg_if.io_cfg_in_valid = 1;
      acc = 0;
      guard = 0;
      while (!acc && guard < 20) begin
        @(negedge clk);
        acc = cfg_if.io_cfg_in_ready;
        align();
        guard++;
      end
      if (!acc) begin
        tests++;
        fails++;
        $display("FAIL send_timeout: word %0d got ready=0 required ready=1", k);
      end
      cfg_if.io_cfg_in_valid = 0;
    end
  endtask

  task automatic commit_check(input string name, input logic [CFG_BITS-1:0] img);
    repeat (3) @(negedge clk);
    check(name, io_mux_configs, img);
    align();
  endtask

  logic [CFG_BITS-1:0] img, prev;

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish required finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    cfg_if.io_cfg_in = '0;
    cfg_if.io_cfg_in_valid = 0;
    repeat (3) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    check("rst_mux", io_mux_configs, '0);
    check("rst_ready", cfg_if.io_cfg_in_ready, 1'b1);
    check("rst_loaded", io_cfg_loaded, 1'b0);
    align();

    // Identity load, back to back
    img = '0;
    for (int i = 0; i < N_OUT; i++) img[i*SEL_W +: SEL_W] = SEL_W'(i % N_IN);
    load_image(img, 2'b00);
    send_words(0, N_WORDS - 1, 0);
    @(negedge clk); check("id_done_t1", io_done, 1'b0);
    @(negedge clk); check("id_done_t2", io_done, 1'b1);
    @(negedge clk);
    check("id_f1", io_mux_configs[9:5], 5'd1);
    check("id_f23", io_mux_configs[119:115], 5'd0);
    check("id_loaded", io_cfg_loaded, 1'b1);
    check("id_err", io_cfg_err, 1'b0);
    align();

    // Out-of-range select in field 5
    prev = img;
    img[29:25] = 5'h17;
    load_image(img, 2'b00);
    send_words(0, N_WORDS - 1, 0);
    @(negedge clk);
    @(negedge clk);
`ifdef XBAR_CFG_RANGE_CHECK_EN
    check("rng_err", io_cfg_err, 1'b1);
    check("rng_no_done", io_done, 1'b0);
    @(negedge clk);
    check("rng_keep", io_mux_configs, prev);
`else
    check("rng_unchecked_done", io_done, 1'b1);
    @(negedge clk);
    check("rng_unchecked_mux", io_mux_configs, img);
`endif
    align();
    img = rand_image(0);
    load_image(img, 2'($urandom));
    send_words(0, N_WORDS - 1, 1);
    commit_check("rng_recover", img);
    check("rng_err_clear", io_cfg_err, 1'b0);

    // Random valid gaps with a long stall after word 7
    img = rand_image(0);
    load_image(img, 2'($urandom));
    send_words(0, 7, 1);
    repeat (10) begin
      cfg_if.io_cfg_in = 8'($urandom);
      align();
    end
    send_words(8, N_WORDS - 1, 1);
    commit_check("bp_img", img);

    // Abort after word 7, then a full reload
    prev = img;
    img = rand_image(0);
    load_image(img, 2'b00);
    send_words(0, 7, 1);
    io_abort = 1; align(); io_abort = 0;
    check("ab7_no_commit", io_mux_configs, prev);
    send_words(0, N_WORDS - 1, 0);
    commit_check("ab7_reload", img);

    // Abort coinciding with word 12
    prev = img;
    img = rand_image(0);
    load_image(img, 2'b00);
    send_words(0, 11, 0);
    cfg_if.io_cfg_in = tx[12];
    cfg_if.io_cfg_in_valid = 1;
    io_abort = 1;
    align();
    io_abort = 0;
    cfg_if.io_cfg_in_valid = 0;
    send_words(0, N_WORDS - 1, 1);
    commit_check("ab12_reload", img);

    // Abort during the check cycle suppresses the commit
    prev = img;
    img = rand_image(0);
    load_image(img, 2'b00);
    send_words(0, N_WORDS - 1, 0);
    io_abort = 1; align(); io_abort = 0;
    @(negedge clk); check("abchk_no_done", io_done, 1'b0);
    @(negedge clk); check("abchk_keep", io_mux_configs, prev);
    align();

    // Final word 8'hC5: only its low six bits land in the image
    img = rand_image(0);
    img[149:145] = 5'd2;
    img[144:140] = SEL_W'(16 + $urandom_range(6, 0));
    load_image(img, 2'b11);
    send_words(0, N_WORDS - 1, 1);
    commit_check("pad_img", img);
    check("pad_bits", io_mux_configs[149:144], 6'h05);
    check("pad_err", io_cfg_err, 1'b0);

    // Randomized mix of good and bad images
    for (int r = 0; r < 8; r++) begin
      img = rand_image($urandom_range(2, 0) == 0);
      load_image(img, 2'($urandom));
      send_words(0, N_WORDS - 1, 1);
    end
    repeat (4) align();

    // Reset partway through a load after a committed image
    img = rand_image(0);
    load_image(img, 2'b00);
    send_words(0, N_WORDS - 1, 0);
    commit_check("pre_rst_img", img);
    img = rand_image(0);
    load_image(img, 2'b00);
    send_words(0, 9, 1);
    reset = 1; align(); reset = 0;
    @(negedge clk);
    check("mid_rst_mux", io_mux_configs, '0);
    check("mid_rst_loaded", io_cfg_loaded, 1'b0);
    check("mid_rst_ready", cfg_if.io_cfg_in_ready, 1'b1);
    check("mid_rst_done", io_done, 1'b0);
    check("mid_rst_err", io_cfg_err, 1'b0);
    align();
    send_words(0, N_WORDS - 1, 0);
    commit_check("post_rst_img", img);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
